// File: rtl/ps2_pkg.sv
// Shared constants and frame-check helper for the PS/2 receive path.
package ps2_pkg;
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DEPTH_DEF  = 8;
    localparam int PS2_BIT_START  = 0;
    localparam int PS2_BIT_PAR    = 9;
    localparam int PS2_BIT_STOP   = 10;

    // Start low, stop high, odd parity over d0..d7 plus the parity bit.
    function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
        return (f[PS2_BIT_START] == 1'b0) && f[PS2_BIT_STOP] && (^f[PS2_BIT_PAR:1]);
    endfunction
endpackage

// File: rtl/ps2_byte_fifo.sv
// DEPTH x 8 register FIFO; pointers carry one extra wrap bit so full/empty
// fall out of the pointer difference.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = PS2_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr, r_rptr;
    logic [AW:0] w_count;
    logic        w_pop, w_wr;
    logic [7:0]  r_mem [DEPTH];

    assign w_count = r_wptr - r_rptr;
    assign o_full  = (w_count == (AW+1)'(DEPTH));
    assign o_empty = (w_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise, deframe, check, and queue bytes
// for the key-processing stage.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = PS2_DEPTH_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_nextdata_n,
    output logic [7:0] o_data,
    output logic       o_ready,
    output logic       o_overflow,
    output logic       o_frame_err
);
    localparam int          IW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic [3:0]    r_bitcnt;
    logic [IW-1:0] r_idle;
    // Only the ten earlier bits are stored; the stop bit is taken live.
    logic [PS2_FRAME_BITS-2:0] r_shift;
    logic          r_overflow, r_frame_err;

    logic                      w_fall, w_bit, w_last, w_ok;
    logic                      w_push, w_bad, w_timeout, w_pop;
    logic                      w_full, w_empty;
    logic [PS2_FRAME_BITS-1:0] w_frame;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_data};
        end
    end

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[1];
    assign w_last    = w_fall && (r_bitcnt == LAST_BIT);
    assign w_frame   = {w_bit, r_shift};
    assign w_ok      = ps2_frame_ok(w_frame);
    assign w_push    = w_last & w_ok;
    assign w_bad     = w_last & ~w_ok;
    assign w_timeout = ~w_fall && (r_bitcnt != 4'd0) && (r_idle == IW'(TIMEOUT_CYCLES - 1));
    assign w_pop     = o_ready & ~i_nextdata_n;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_idle   <= '0;
        end else if (w_fall) begin
            r_shift  <= {w_bit, r_shift[PS2_FRAME_BITS-2:1]};
            r_idle   <= '0;
            r_bitcnt <= w_last ? 4'd0 : r_bitcnt + 4'd1;
        end else if (r_bitcnt != 4'd0) begin
            if (w_timeout) begin
                r_bitcnt <= '0;
                r_idle   <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_bad | w_timeout;
            if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
        end
    end

    ps2_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_frame[8:1]),
        .o_rdata (o_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_ready     = ~w_empty;
    assign o_overflow  = r_overflow;
    assign o_frame_err = r_frame_err;
endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 device-to-host receiver with a small read FIFO. It synchronises the raw keyboard `ps2_clk`/`ps2_data` pins, deframes 11-bit frames and checks their framing and parity. Valid scan-code bytes are queued for the key-processing stage, which drains them through a `ready`/`nextdata_n` handshake. Framing errors and FIFO overflow are reported.

## Interface
- `DEPTH`, 8: FIFO capacity in bytes; power of two, at least 2.
- `TIMEOUT_CYCLES`, 4096: idle `clk` cycles mid-frame before the frame is abandoned.
- `clk`  in  1  system clock.
- `clrn`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `nextdata_n`  in  1  active-low pop request; honoured only while `ready`=1.
- `data`  out  8  byte at FIFO head; valid while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky flag: a valid byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse on a bad or abandoned frame.

## Operation
- **Synchronisers:** 3-flop synchroniser on `ps2_clk`, 2-flop synchroniser on `ps2_data`.
- **Edge detect:** a falling edge is detected when the two oldest `ps2_clk` sync stages read 1 then 0. Synchronised data is sampled on that cycle.
- **Bit counter:** counts 0..10. Bits are shifted into an 11-bit register, LSB first: start, d0..d7, parity, stop.
- **Frame check, on the 11th edge:**
  - Valid when start=0, stop=1, and the XOR of d0..d7 and parity is 1 (odd parity).
  - Valid frame: the byte is pushed.
  - Invalid frame: the byte is discarded and `frame_err` pulses.
  - In both cases the counter returns to 0.
- **Timeout:** an idle counter resets on every detected edge. If the bit counter is non-zero and `TIMEOUT_CYCLES` cycles pass with no edge, the counter returns to 0 and `frame_err` pulses. The partial frame is discarded.
- **FIFO pointers:** read and write pointers are $clog2(DEPTH)+1 bits wide and wrap naturally. Count = wptr − rptr. Empty when count=0; full when count=DEPTH.
- **Pop:** occurs when `ready`=1 and `nextdata_n`=0 at a `clk` edge. `nextdata_n`=0 with `ready`=0 is ignored.
- **Push:** accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped, the FIFO is unchanged, and `overflow` is set to 1.
  - `overflow` clears only on reset.
- **Read port:** `data` = storage[rptr] (combinational from registers); `ready` = (count≠0).
- **Reset (`clrn`=0):**
  - Pointers, bit counter, idle counter, shift register, `overflow` and `frame_err` clear to 0.
  - Synchroniser flops reset to 1 (idle bus).
  - Therefore `ready`=0 and `data`=storage[0]; storage contents are don't-care.
- **Reset mid-frame:** the partial frame is lost, with no `frame_err` pulse after release.

## Timing
- Raw `ps2_clk` fall to detected edge: 3 `clk` cycles, ±1 for metastability resolution.
- `ready` rises 1 cycle after the detected edge of the stop bit.
- **Pop:** `rptr` advances at the popping edge, so `data` shows the next entry, or `ready` falls, in the following cycle. Holding `nextdata_n`=0 drains one byte per cycle.
- **Simultaneous push and pop:** count is unchanged. When full, the push succeeds (see the push rule).
- `frame_err` is high for exactly one cycle per failure.
- `clk` must be at least 8× the fastest `ps2_clk` (16.7 kHz) so no edge is missed.

## Structure
- **Package `ps2_pkg`:** `PS2_FRAME_BITS`=11, the default `DEPTH`, and the bit-position constants (START=0, PAR=9, STOP=10).
- **Sub-module `ps2_byte_fifo`:** parameterised `DEPTH`×8 register FIFO with push, pop, count, full and empty.
- Top-level `ps2_rx_fifo` keeps the synchronisers, edge detector, deframer and timeout.

## Test plan
- **Single byte:** send scan code 0x1C with parity 0 -> `ready`=1 and `data`=0x1C. Pop -> `ready`=0 next cycle; `frame_err` never pulses.
- **Bad parity:** send 0x1C with parity 1 -> one `frame_err` pulse, `ready` stays 0. Then send 0xF0 correctly -> `data`=0xF0.
- **Overflow:** with `nextdata_n`=1, send 9 bytes 0x01..0x09 (`DEPTH`=8) -> `overflow`=1. Draining yields 0x01..0x08, then `ready`=0.
- **Full and pop together:** FIFO full, pop on the same cycle as the 9th frame completes -> `overflow` stays 0 and 0x09 is the last byte read.
- **Timeout:** send 4 bits, then idle for 4096 cycles -> one `frame_err` pulse. A following full frame of 0x5A is received correctly.
- **Reset mid-frame:** assert `clrn` after 6 bits -> `ready`=0 and `overflow`=0. Then send 0x29 -> `data`=0x29.
